mpadder_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 1027-bit mpadder instance among NREQ requesters, e.g. the Montgomery multiplier and the exponentiation controller.
- Per transaction it latches the winning requester's operands and sends the adder a one-cycle start pulse. It then waits for done, captures the result and returns it to that requester with a one-cycle response pulse.
- A watchdog reports a hung adder instead of deadlocking.

---
 rtl/mpadder_arbiter.sv | 152 +++++++++++++++
 tb/tb_mpadder_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpadder_arbiter.sv
// mpadder_arbiter: round-robin arbiter and sequencer that shares one wide mpadder among NREQ
// requesters. For each transaction it latches the winner's operands, pulses add_start, waits
// for add_done or a watchdog expiry, then returns the result with a one-cycle response pulse.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   req_valid/req_sub   per-requester request and op (1 = a-b, 0 = a+b)
//   req_a/req_b         flattened operands, requester i at [i*W +: W]
//   resp_valid          one-hot, one-cycle response pulse
//   resp_err            1 = watchdog timeout, result invalid (0)
//   resp_result         W+1-bit result, valid in the resp_valid cycle
//   busy                high whenever the sequencer is not idle
//   add_start           one-cycle start pulse to the adder
//   add_subtract/add_in_a/add_in_b  registered op and operands to the adder
//   add_result/add_done adder result and completion pulse
module mpadder_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned W       = 1027,
  parameter int unsigned TIMEOUT = 16   // must be >= 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_sub,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  output logic              resp_err,
  output logic [W:0]        resp_result,
  output logic              busy,
  output logic              add_start,
  output logic              add_subtract,
  output logic [W-1:0]      add_in_a,
  output logic [W-1:0]      add_in_b,
  input  logic [W:0]        add_result,
  input  logic              add_done
);

  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StResp} state_e;

  state_e          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   grant_q;
  logic [WDW-1:0]  wd_q;

  logic [PW-1:0]   grant_d;
  logic            grant_found;
  logic [PW-1:0]   cand;
  int unsigned     scan;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_sub;
  logic [NREQ-1:0] grant_onehot;

  // First requesting index at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    grant_d     = ptr_q;
    grant_found = 1'b0;
    scan        = 0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = 32'(ptr_q) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      cand = PW'(scan);
      if (!grant_found && req_valid[cand]) begin
        grant_d     = cand;
        grant_found = 1'b1;
      end
    end
  end

  // Operand mux and response one-hot for the recorded grant.
  always_comb begin
    sel_a        = '0;
    sel_b        = '0;
    sel_sub      = 1'b0;
    grant_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == PW'(i)) begin
        sel_a           = req_a[i*W +: W];
        sel_b           = req_b[i*W +: W];
        sel_sub         = req_sub[i];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      grant_q      <= '0;
      wd_q         <= '0;
      resp_valid   <= '0;
      resp_err     <= 1'b0;
      resp_result  <= '0;
      busy         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= '0;
      add_in_b     <= '0;
    end else begin
      add_start  <= 1'b0;
      resp_valid <= '0;
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            grant_q <= grant_d;
            busy    <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          add_in_a     <= sel_a;
          add_in_b     <= sel_b;
          add_subtract <= sel_sub;
          add_start    <= 1'b1;   // high during StStart
          state_q      <= StStart;
        end
        StStart: begin
          wd_q    <= '0;
          state_q <= StWait;
        end
        StWait: begin
          wd_q <= wd_q + WDW'(1);
          if (add_done) begin
            resp_result <= add_result;
            resp_err    <= 1'b0;
            resp_valid  <= grant_onehot;
            state_q     <= StResp;
          end else if (wd_q == WDW'(TIMEOUT - 2)) begin
            // Count would reach TIMEOUT-1 this cycle: give up on the adder.
            resp_result <= '0;
            resp_err    <= 1'b1;
            resp_valid  <= grant_onehot;
            state_q     <= StResp;
          end
        end
        StResp: begin
          ptr_q   <= (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + PW'(1);
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mpadder_arbiter.sv
module tb_mpadder_arbiter;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned W       = 1027;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned RW      = W + 1;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   resp_valid;
  logic              resp_err;
  logic [W:0]        resp_result;
  logic              busy;
  logic              add_start;
  logic              add_subtract;
  logic [W-1:0]      add_in_a;
  logic [W-1:0]      add_in_b;
  logic [W:0]        add_result;
  logic              add_done;

  mpadder_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_sub     (req_sub),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_result (resp_result),
    .busy        (busy),
    .add_start   (add_start),
    .add_subtract(add_subtract),
    .add_in_a    (add_in_a),
    .add_in_b    (add_in_b),
    .add_result  (add_result),
    .add_done    (add_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests, fails, cyc;

  // Adder model: done pulses cur_lat cycles after add_start (0 = never).
  int unsigned cur_lat;
  int          done_cnt;
  logic        spur_done;
  logic [W:0]  pend_result;

  // Transaction-level reference model for the random phase.
  logic       rand_on;
  logic       m_act;
  int         m_grant, m_grant_cyc, m_resp_cyc, m_idle_from, m_ptr;
  logic [W:0] m_res;
  logic       m_err;

  typedef struct {
    int          idx;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic        sub;
    int unsigned lat;
    logic [W:0]  exp_res;
    logic        exp_err;
    int          exp_delay;   // cycles from add_start to resp_valid
  } vec_t;

  vec_t vecs[8];
  int   exp_order[4];

  task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h..%h, want %h..%h", name, got[W:W-31], got[63:0],
               exp[W:W-31], exp[63:0]);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [33*32-1:0] t;
    int unsigned m;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    m = $urandom_range(0, 7);
    if (m == 0) t = '0;
    else if (m == 1) t = '1;
    return t[W-1:0];
  endfunction

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
    return sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  endfunction

  task automatic rand_cycle();
    logic [NREQ-1:0] exp_rv;
    int unsigned lat;
    int j;
    exp_rv = '0;
    if (m_act && cyc == m_resp_cyc) exp_rv[m_grant] = 1'b1;
    chk("rand resp_valid", RW'(resp_valid), RW'(exp_rv));
    chk("rand busy", RW'(busy), RW'(m_act && cyc > m_grant_cyc));
    chk("rand add_start", RW'(add_start), RW'(m_act && cyc == m_grant_cyc + 2));
    if (exp_rv != '0) begin
      chk("rand resp_result", resp_result, m_res);
      chk("rand resp_err", RW'(resp_err), RW'(m_err));
      req_valid[m_grant] = 1'b0;
      m_ptr       = (m_grant + 1) % NREQ;
      m_act       = 1'b0;
      m_idle_from = cyc + 1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!req_valid[i]) begin
        if ($urandom_range(0, 3) == 0) begin
          req_valid[i]    = 1'b1;
          req_sub[i]      = 1'($urandom_range(0, 1));
          req_a[i*W +: W] = rand_op();
          req_b[i*W +: W] = rand_op();
        end
      end else if ($urandom_range(0, 7) == 0) begin
        req_a[i*W +: W] = rand_op();
      end
    end
    if (m_act && cyc == m_grant_cyc + 1 && !m_err)
      m_res = ref_add(req_a[m_grant*W +: W], req_b[m_grant*W +: W], req_sub[m_grant]);
    if (!m_act && cyc >= m_idle_from) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (!m_act && req_valid[j]) begin
          m_act       = 1'b1;
          m_grant     = j;
          m_grant_cyc = cyc;
          lat         = $urandom_range(0, 17);
          cur_lat     = lat;
          if (lat >= 1 && lat <= TIMEOUT - 1) begin
            m_err      = 1'b0;
            m_resp_cyc = cyc + 3 + int'(lat);
          end else begin
            m_err      = 1'b1;
            m_res      = '0;
            m_resp_cyc = cyc + 2 + int'(TIMEOUT);
          end
        end
      end
    end
  endtask

  // One clock: advance, then drive the adder model and optional random phase.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    add_done   = 1'b0;
    add_result = pend_result + RW'(1);   // junk unless done
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        add_done   = 1'b1;
        add_result = pend_result;
      end
    end
    if (spur_done) begin
      add_done   = 1'b1;
      add_result = '1;
      spur_done  = 1'b0;
    end
    if (add_start) begin
      pend_result = ref_add(add_in_a, add_in_b, add_subtract);
      done_cnt    = int'(cur_lat);
    end
    if (rand_on) rand_cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " resp_valid"}, RW'(resp_valid), '0);
    chk({tag, " resp_err"}, RW'(resp_err), '0);
    chk({tag, " resp_result"}, resp_result, '0);
    chk({tag, " busy"}, RW'(busy), '0);
    chk({tag, " add_start"}, RW'(add_start), '0);
    chk({tag, " add_subtract"}, RW'(add_subtract), '0);
    chk({tag, " add_in_a"}, RW'(add_in_a), '0);
    chk({tag, " add_in_b"}, RW'(add_in_b), '0);
  endtask

  task automatic run_vec(input vec_t v);
    int t_start, t_resp, n_start;
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[v.idx] = 1'b1;
    req_a[v.idx*W +: W] = v.a;
    req_b[v.idx*W +: W] = v.b;
    req_sub[v.idx]      = v.sub;
    req_valid[v.idx]    = 1'b1;
    cur_lat = v.lat;
    t_start = -1000;
    t_resp  = -1;
    n_start = 0;
    for (int k = 0; k < 40 && t_resp < 0; k++) begin
      step();
      if (add_start) begin
        n_start++;
        t_start = cyc;
        chk("vec add_subtract", RW'(add_subtract), RW'(v.sub));
        chk("vec add_in_a", RW'(add_in_a), RW'(v.a));
        chk("vec add_in_b", RW'(add_in_b), RW'(v.b));
      end
      if (resp_valid != '0) begin
        t_resp = cyc;
        chk("vec resp_valid", RW'(resp_valid), RW'(oh));
        chk("vec resp_result", resp_result, v.exp_res);
        chk("vec resp_err", RW'(resp_err), RW'(v.exp_err));
        req_valid[v.idx] = 1'b0;
      end
    end
    req_valid[v.idx] = 1'b0;
    chk("vec start pulses", RW'(n_start), RW'(1));
    chk("vec delay", RW'(t_resp - t_start), RW'(v.exp_delay));
    step();
    chk("vec busy after resp", RW'(busy), '0);
  endtask

  initial begin
    int n_resp, n_start;
    logic started, got, seen;
    logic [W-1:0] top;
    logic [W:0] big_res;

    tests = 0; fails = 0; cyc = 0;
    cur_lat = 5; done_cnt = 0; spur_done = 1'b0; pend_result = '0;
    rand_on = 1'b0; m_act = 1'b0; m_ptr = 0; m_idle_from = 0;
    m_grant = 0; m_grant_cyc = 0; m_resp_cyc = 0; m_res = '0; m_err = 1'b0;
    reset = 1'b1;
    req_valid = '0; req_sub = '0; req_a = '0; req_b = '0;
    add_result = '0; add_done = 1'b0;

    top     = {1'b1, {(W-1){1'b0}}};
    big_res = {2'b00, {(W-1){1'b1}}};
    vecs[0] = '{0, W'(5),  W'(3), 1'b0, 5,  RW'(8), 1'b0, 6};
    vecs[1] = '{1, top,    W'(1), 1'b1, 3,  big_res, 1'b0, 4};
    vecs[2] = '{0, '1,     W'(1), 1'b0, 1,  {1'b1, {W{1'b0}}}, 1'b0, 2};
    vecs[3] = '{1, W'(3),  W'(5), 1'b1, 2,  {{W{1'b1}}, 1'b0}, 1'b0, 3};
    vecs[4] = '{0, W'(7),  W'(7), 1'b0, 0,  '0, 1'b1, 16};
    vecs[5] = '{1, W'(9),  W'(1), 1'b0, 15, RW'(10), 1'b0, 16};
    vecs[6] = '{0, W'(4),  W'(4), 1'b0, 16, '0, 1'b1, 16};
    vecs[7] = '{1, W'(100), W'(1), 1'b0, 1, RW'(101), 1'b0, 2};
    exp_order = '{0, 1, 0, 1};

    // Reset state.
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;

    // Both requesting from reset: grants alternate 0,1,0,1.
    req_a[0 +: W] = W'(5); req_b[0 +: W] = W'(3); req_sub[0] = 1'b0;
    req_a[W +: W] = top;   req_b[W +: W] = W'(1); req_sub[1] = 1'b1;
    req_valid = '1;
    cur_lat = 5;
    n_resp = 0; n_start = 0;
    for (int k = 0; k < 200 && n_resp < 4; k++) begin
      step();
      if (add_start && n_start < 4) begin
        chk("rr add_subtract", RW'(add_subtract), RW'(exp_order[n_start] == 1));
        n_start++;
      end
      if (resp_valid != '0) begin
        chk("rr grant", RW'(resp_valid), RW'(exp_order[n_resp] == 0 ? 2'b01 : 2'b10));
        chk("rr result", resp_result, exp_order[n_resp] == 0 ? RW'(8) : big_res);
        chk("rr err", RW'(resp_err), '0);
        n_resp++;
      end
    end
    req_valid = '0;
    chk("rr responses", RW'(n_resp), RW'(4));
    step();

    // Single-requester vectors, including timeout and done-at-expiry corners.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Operands changed after LOAD must not reach the adder.
    req_a[0 +: W] = W'(11); req_b[0 +: W] = W'(1); req_sub[0] = 1'b0;
    req_valid[0] = 1'b1;
    cur_lat = 6;
    started = 1'b0; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (add_start) started = 1'b1;
      if (started) chk("hold add_in_a", RW'(add_in_a), RW'(11));
      if (add_start) begin
        req_a[0 +: W] = '1;
        req_b[0 +: W] = '1;
      end
      if (resp_valid != '0) begin
        got = 1'b1;
        chk("hold result", resp_result, RW'(12));
        req_valid[0] = 1'b0;
      end
    end
    req_valid[0] = 1'b0;
    chk("hold resp seen", RW'(got), RW'(1));
    step();

    // Spurious add_done while idle.
    spur_done = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (resp_valid != '0 || busy) seen = 1'b1;
    end
    chk("spurious done", RW'(seen), '0);

    // Reset during WAIT (pointer is 1 here), then re-request: grant from 0.
    req_a[0 +: W] = W'(20); req_b[0 +: W] = W'(22); req_sub[0] = 1'b0;
    req_valid[0] = 1'b1;
    cur_lat = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (add_start) got = 1'b1;
    end
    chk("wait start seen", RW'(got), RW'(1));
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    req_valid = '0;
    done_cnt = 0;
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (resp_valid != '0) seen = 1'b1;
    end
    chk("no resp after reset", RW'(seen), '0);
    req_a[W +: W] = W'(1); req_b[W +: W] = W'(1); req_sub[1] = 1'b0;
    req_valid = '1;
    cur_lat = 3;
    n_resp = 0;
    for (int k = 0; k < 60 && n_resp < 2; k++) begin
      step();
      if (resp_valid != '0) begin
        chk("post-reset grant", RW'(resp_valid), RW'(n_resp == 0 ? 2'b01 : 2'b10));
        chk("post-reset result", resp_result, n_resp == 0 ? RW'(42) : RW'(2));
        req_valid = resp_valid ^ req_valid;
        n_resp++;
      end
    end
    req_valid = '0;
    chk("post-reset responses", RW'(n_resp), RW'(2));
    step();

    // Random traffic against the transaction-level model.
    m_act = 1'b0; m_ptr = 0; m_idle_from = 0;
    rand_on = 1'b1;
    repeat (3000) step();
    rand_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
